// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the UART receive oversampler.
package uart_rx_pkg;

  localparam int MIN_PRESCALE = 8;
  localparam int VOTES_LO     = 3;
  localparam int VOTES_HI     = 5;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } rx_state_e;

  function automatic int vote_width(input int votes);
    return $clog2(votes + 1);
  endfunction

  function automatic logic votes_legal(input int votes);
    return (votes == VOTES_LO) || (votes == VOTES_HI);
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-stage synchroniser for a single asynchronous bit; resets to the line idle level.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync;

  // shift register; stage 0 captures the raw input
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= {STAGES{1'b1}};
    end else begin
      sync <= {sync[STAGES-2:0], d};
    end
  end

  assign q = sync[STAGES-1];

endmodule

// File: rtl/uart_rx_oversampler.sv
// Bit-period counter and majority-vote sampler for a UART receive line.
// Each bit period is prescale_q clocks; votes are taken around the bit centre.
module uart_rx_oversampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6,
  parameter int VOTES      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic                  dat_samp_en,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  sampled_bit,
  output logic                  sample_valid,
  output logic                  noise_err,
  output logic                  cfg_err,
  output logic [PRESCALE_W-1:0] edge_cnt
);

  localparam int VW   = vote_width(VOTES);
  localparam int HALF = (VOTES - 1) / 2;

  localparam logic [PRESCALE_W-1:0] ONE_P  = {{(PRESCALE_W-1){1'b0}}, 1'b1};
  localparam logic [PRESCALE_W-1:0] HALF_P = PRESCALE_W'(HALF);
  localparam logic [PRESCALE_W-1:0] MIN_P  = PRESCALE_W'(MIN_PRESCALE);
  localparam logic [VW-1:0]         ONE_V  = {{(VW-1){1'b0}}, 1'b1};
  localparam logic [VW-1:0]         MAX_V  = VW'(VOTES);
  localparam logic [VW-1:0]         MAJ_V  = VW'(VOTES / 2);

  generate
    if (!votes_legal(VOTES)) begin : g_bad_votes
      $error("uart_rx_oversampler: VOTES must be 3 or 5");
    end
  endgenerate

  logic                  rx_sync;
  logic [PRESCALE_W-1:0] prescale_q;
  logic [VW-1:0]         ones_cnt;
  logic [VW-1:0]         zeros_cnt;

  rx_state_e             state;
  logic [PRESCALE_W-1:0] prescale_nxt;
  logic                  cfg_err_nxt;
  logic [PRESCALE_W-1:0] edge_nxt;
  logic [VW-1:0]         ones_nxt;
  logic [VW-1:0]         zeros_nxt;
  logic                  sampled_nxt;
  logic                  noise_nxt;
  logic                  valid_nxt;
  logic [PRESCALE_W-1:0] mid;
  logic [PRESCALE_W-1:0] last_edge;
  logic                  in_window;

  bit_sync #(.STAGES(2)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (RX_IN),
    .q   (rx_sync)
  );

  // state register bank: configuration, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      prescale_q   <= MIN_P;
      cfg_err      <= 1'b0;
      edge_cnt     <= {PRESCALE_W{1'b0}};
      ones_cnt     <= {VW{1'b0}};
      zeros_cnt    <= {VW{1'b0}};
      sampled_bit  <= 1'b0;
      noise_err    <= 1'b0;
      sample_valid <= 1'b0;
    end else begin
      prescale_q   <= prescale_nxt;
      cfg_err      <= cfg_err_nxt;
      edge_cnt     <= edge_nxt;
      ones_cnt     <= ones_nxt;
      zeros_cnt    <= zeros_nxt;
      sampled_bit  <= sampled_nxt;
      noise_err    <= noise_nxt;
      sample_valid <= valid_nxt;
    end
  end

  // next-state: counting is decided by the current enable, so a fresh bit starts at edge 0 at once
  always_comb begin
    prescale_nxt = prescale_q;
    cfg_err_nxt  = prescale_q[0] | (prescale_q < MIN_P);
    edge_nxt     = {PRESCALE_W{1'b0}};
    ones_nxt     = {VW{1'b0}};
    zeros_nxt    = {VW{1'b0}};
    sampled_nxt  = sampled_bit;
    noise_nxt    = noise_err;
    valid_nxt    = 1'b0;
    mid          = prescale_q >> 1;
    last_edge    = prescale_q - ONE_P;
    in_window    = (edge_cnt >= (mid - HALF_P)) && (edge_cnt <= (mid + HALF_P));

    if (dat_samp_en && !cfg_err) begin
      state = ST_COUNT;
    end else begin
      state = ST_IDLE;
    end

    if (!dat_samp_en) begin
      prescale_nxt = prescale;
    end else begin
      prescale_nxt = prescale_q;
    end

    case (state)
      ST_COUNT: begin
        if (edge_cnt == last_edge) begin
          sampled_nxt = (ones_cnt > MAJ_V);
          noise_nxt   = (ones_cnt != {VW{1'b0}}) && (zeros_cnt != {VW{1'b0}});
          valid_nxt   = 1'b1;
        end else begin
          edge_nxt  = edge_cnt + ONE_P;
          ones_nxt  = ones_cnt;
          zeros_nxt = zeros_cnt;
          if (in_window && rx_sync && (ones_cnt < MAX_V)) begin
            ones_nxt = ones_cnt + ONE_V;
          end else if (in_window && !rx_sync && (zeros_cnt < MAX_V)) begin
            zeros_nxt = zeros_cnt + ONE_V;
          end else begin
            ones_nxt = ones_cnt;
          end
        end
      end
      ST_IDLE: begin
        edge_nxt = {PRESCALE_W{1'b0}};
      end
      default: begin
        edge_nxt = {PRESCALE_W{1'b0}};
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Self-checking bench: two oversamplers (3 and 5 votes) run in lockstep against a
// per-bit reference built from the line waveform the bench itself generates.
module tb_uart_rx_oversampler;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       en;
  logic [5:0] prescale;

  logic       sb [2];
  logic       sv [2];
  logic       ne [2];
  logic       ce [2];
  logic [5:0] ec [2];

  int   checks = 0;
  int   passes = 0;
  bit   line_q[$];
  logic last_sb [2];
  logic obs_sb  [2];
  logic obs_ne  [2];
  int   pulse_cnt;

  always #5 clk = ~clk;

  uart_rx_oversampler #(.PRESCALE_W(6), .VOTES(3)) dut3 (
    .clk(clk), .rst(rst), .RX_IN(rx), .dat_samp_en(en), .prescale(prescale),
    .sampled_bit(sb[0]), .sample_valid(sv[0]), .noise_err(ne[0]),
    .cfg_err(ce[0]), .edge_cnt(ec[0])
  );

  uart_rx_oversampler #(.PRESCALE_W(6), .VOTES(5)) dut5 (
    .clk(clk), .rst(rst), .RX_IN(rx), .dat_samp_en(en), .prescale(prescale),
    .sampled_bit(sb[1]), .sample_valid(sv[1]), .noise_err(ne[1]),
    .cfg_err(ce[1]), .edge_cnt(ec[1])
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // number of '1' votes a receiver with `votes` samples sees for bit `bi` of line_q
  function automatic int ones_in(input int bi, input int p, input int votes);
    int n;
    n = 0;
    for (int e = p / 2 - (votes - 1) / 2; e <= p / 2 + (votes - 1) / 2; e++)
      n += int'(line_q[bi * p + e]);
    return n;
  endfunction

  task automatic set_prescale(input int p);
    logic exp_ce;
    en = 1'b0;
    prescale = 6'(p);
    tick(); tick(); tick();
    exp_ce = ((p % 2) != 0) || (p < 8);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ce[d] !== exp_ce) $display("FAIL cfg_err dut%0d p=%0d got %b want %b", d, p, ce[d], exp_ce);
      else passes++;
    end
  endtask

  // nbits back-to-back bits of `data`; noise flips random edges, flip>=0 inverts that edge of bit 0
  task automatic run_burst(input int p, input int nbits, input logic [31:0] data,
                           input int noise, input int flip);
    int n;
    line_q.delete();
    for (int i = 0; i < nbits; i++)
      for (int e = 0; e < p; e++) begin
        bit b;
        b = data[i];
        if (noise != 0 && $urandom_range(0, 5) == 0) b = ~b;
        if (i == 0 && e == flip) b = ~b;
        line_q.push_back(b);
      end
    n = nbits * p;
    pulse_cnt = 0;
    for (int d = 0; d < 2; d++) begin obs_sb[d] = 1'bx; obs_ne[d] = 1'bx; end
    en = 1'b0; rx = line_q[0]; tick();
    rx = line_q[1]; tick();
    for (int c = 0; c < n; c++) begin
      en = 1'b1;
      rx = (c + 2 < n) ? line_q[c + 2] : 1'b1;
      tick();
      if (sv[0] === 1'b1) pulse_cnt++;
      for (int d = 0; d < 2; d++) begin
        int   v, ones;
        logic exp_v, exp_b, exp_n;
        v = (d == 0) ? 3 : 5;
        exp_v = ((c % p) == p - 1);
        checks++;
        if (sv[d] !== exp_v) $display("FAIL sample_valid dut%0d c=%0d got %b want %b", d, c, sv[d], exp_v);
        else passes++;
        checks++;
        if (ec[d] !== 6'((c + 1) % p)) $display("FAIL edge_cnt dut%0d c=%0d got %0d want %0d", d, c, ec[d], (c + 1) % p);
        else passes++;
        if (exp_v) begin
          ones  = ones_in(c / p, p, v);
          exp_b = (ones > v / 2);
          exp_n = (ones != 0) && (ones != v);
          obs_sb[d] = sb[d];
          obs_ne[d] = ne[d];
          last_sb[d] = exp_b;
          checks++;
          if (sb[d] !== exp_b) $display("FAIL sampled_bit dut%0d bit=%0d got %b want %b", d, c / p, sb[d], exp_b);
          else passes++;
          checks++;
          if (ne[d] !== exp_n) $display("FAIL noise_err dut%0d bit=%0d got %b want %b", d, c / p, ne[d], exp_n);
          else passes++;
        end
      end
    end
    en = 1'b0; rx = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (sv[d] !== 1'b0 || ec[d] !== 6'd0 || sb[d] !== last_sb[d])
        $display("FAIL idle_hold dut%0d got sv=%b ec=%0d sb=%b want sv=0 ec=0 sb=%b", d, sv[d], ec[d], sb[d], last_sb[d]);
      else passes++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; rx = 1'b1; prescale = 6'd8;
    tick(); tick();
    rst = 1'b0;
    tick();
    for (int d = 0; d < 2; d++) begin
      last_sb[d] = 1'b0;
      checks++;
      if ({sb[d], sv[d], ne[d], ce[d]} !== 4'b0000 || ec[d] !== 6'd0)
        $display("FAIL reset dut%0d got sb=%b sv=%b ne=%b ce=%b ec=%0d want all 0", d, sb[d], sv[d], ne[d], ce[d], ec[d]);
      else passes++;
    end
  endtask

  task automatic test_scn1();
    set_prescale(8);
    run_burst(8, 1, 32'h0, 0, -1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs_sb[d] !== 1'b0 || obs_ne[d] !== 1'b0)
        $display("FAIL scn1 dut%0d got sb=%b ne=%b want sb=0 ne=0", d, obs_sb[d], obs_ne[d]);
      else passes++;
    end
  endtask

  task automatic test_scn2();
    set_prescale(16);
    run_burst(16, 1, 32'h1, 0, 8);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs_sb[d] !== 1'b1 || obs_ne[d] !== 1'b1)
        $display("FAIL scn2 dut%0d got sb=%b ne=%b want sb=1 ne=1", d, obs_sb[d], obs_ne[d]);
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    set_prescale(32);
    run_burst(32, 8, 32'h55, 0, -1);
    checks++;
    if (pulse_cnt != 8) $display("FAIL b2b_pulses got %0d want 8", pulse_cnt);
    else passes++;
  endtask

  task automatic test_cfg_err(input int p);
    set_prescale(p);
    en = 1'b1; rx = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (ec[d] !== 6'd0 || sv[d] !== 1'b0)
          $display("FAIL cfg_idle dut%0d p=%0d got ec=%0d sv=%b want ec=0 sv=0", d, p, ec[d], sv[d]);
        else passes++;
      end
    end
    en = 1'b0; rx = 1'b1;
    tick();
  endtask

  task automatic test_abort();
    set_prescale(8);
    en = 1'b1; rx = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    en = 1'b0;
    tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ec[d] !== 6'd0 || sv[d] !== 1'b0)
        $display("FAIL abort dut%0d got ec=%0d sv=%b want ec=0 sv=0", d, ec[d], sv[d]);
      else passes++;
    end
    run_burst(8, 2, 32'h3, 0, -1);
  endtask

  task automatic test_reset_mid();
    set_prescale(8);
    run_burst(8, 1, 32'h1, 0, -1);
    en = 1'b1; rx = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    rst = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      last_sb[d] = 1'b0;
      checks++;
      if ({sb[d], sv[d], ne[d], ce[d]} !== 4'b0000 || ec[d] !== 6'd0)
        $display("FAIL reset_mid dut%0d got sb=%b sv=%b ne=%b ce=%b ec=%0d want all 0", d, sb[d], sv[d], ne[d], ce[d], ec[d]);
      else passes++;
    end
    rst = 1'b0;
    tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ec[d] !== 6'd1 || sv[d] !== 1'b0)
        $display("FAIL reset_resume dut%0d got ec=%0d sv=%b want ec=1 sv=0", d, ec[d], sv[d]);
      else passes++;
    end
    en = 1'b0;
    tick();
    run_burst(8, 3, $urandom, 1, -1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      int p;
      p = 2 * $urandom_range(4, 31);
      set_prescale(p);
      run_burst(p, $urandom_range(1, 4), $urandom, 1, -1);
    end
  endtask

  initial begin
    test_reset();
    test_scn1();
    test_scn2();
    test_back_to_back();
    test_cfg_err(7);
    test_cfg_err(6);
    test_abort();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_oversampler.md
UART_RX_OVERSAMPLER -- requirements
Module: uart_rx_oversampler

Interface
REQ-001 Parameter PRESCALE_W, default 6: width of the prescale input; prescale values up to 2^PRESCALE_W-1.
REQ-002 Parameter VOTES, default 3: samples per bit for the majority vote; legal values 3 or 5.
REQ-003 Port clk, input, 1: the single clock; all flops on rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port RX_IN, input, 1: asynchronous serial line; idles high.
REQ-006 Port dat_samp_en, input, 1: high enables bit-period counting and sampling; low idles the block.
REQ-007 Port prescale, input, PRESCALE_W: oversampling clocks per bit; legal values are even and at least 8.
REQ-008 Port sampled_bit, output, 1: registered majority result of the last completed bit.
REQ-009 Port sample_valid, output, 1: one-cycle pulse when sampled_bit is updated.
REQ-010 Port noise_err, output, 1: registered with sampled_bit; high when the votes of that bit were not unanimous.
REQ-011 Port cfg_err, output, 1: high while the latched prescale is illegal.
REQ-012 Port edge_cnt, output, PRESCALE_W: current internal edge count, for the downstream bit-counter FSM.

Function
REQ-013 RX_IN shall pass through a 2-flop synchroniser; all sampling uses the synchronised value, giving 2 cycles of input latency.
REQ-014 While dat_samp_en is low, prescale shall be latched every cycle into prescale_q; it is frozen while dat_samp_en is high.
REQ-015 cfg_err shall be high when prescale_q is odd or less than 8; it is updated one cycle after prescale_q.
REQ-016 While cfg_err is high, edge_cnt shall hold 0, votes shall stay cleared, and sample_valid shall never assert.
REQ-017 States: IDLE (dat_samp_en low) and COUNT (dat_samp_en high and cfg_err low).
REQ-018 IDLE: edge_cnt is 0 and both vote counters are 0; sampled_bit and noise_err hold their last values.
REQ-019 COUNT: edge_cnt shall increment by 1 each cycle, and on reaching prescale_q-1 shall wrap to 0 on the next cycle.
REQ-020 With mid = prescale_q>>1 and h = (VOTES-1)/2, a vote shall be taken on each cycle where mid-h <= edge_cnt <= mid+h.
REQ-021 Each vote shall increment ones_cnt if the synchronised RX_IN is 1, otherwise zeros_cnt.
REQ-022 Vote counters shall be $clog2(VOTES+1) bits wide and shall not overflow.
REQ-023 On the cycle with edge_cnt == prescale_q-1, the outputs shall update on the next edge:
  - sampled_bit <= (ones_cnt > VOTES/2)
  - noise_err <= (ones_cnt != 0 && zeros_cnt != 0)
  - sample_valid pulses high for exactly 1 cycle
  - the vote counters clear
REQ-024 sample_valid shall be low in every other cycle.
REQ-025 If dat_samp_en drops mid-bit, the partial votes shall be discarded and edge_cnt shall return to 0 next cycle, with no sample_valid.
REQ-026 If dat_samp_en re-asserts, counting shall restart at edge_cnt 0 in the same cycle it is seen high.
REQ-027 Back-to-back bits shall continue without a gap: after the wrap, edge_cnt 0 begins the next bit.

Reset
REQ-028 rst shall set the following values:
  - synchroniser flops to 1
  - edge_cnt, ones_cnt, zeros_cnt to 0
  - sampled_bit, sample_valid, noise_err to 0
  - prescale_q to 8, so cfg_err is 0
REQ-029 rst shall take priority over dat_samp_en in the same cycle; a reset mid-bit shall produce no sample_valid.

Structure
REQ-030 Package uart_rx_pkg shall hold MIN_PRESCALE=8, the legal VOTES set, and a function vote_width(VOTES).
REQ-031 The synchroniser shall be a sub-module bit_sync with 2 stages, reset value 1, and ports clk, rst, d, q.
REQ-032 Elaboration shall fail for any VOTES value other than 3 or 5.

Verification
REQ-033 Scenario 1: prescale=8, VOTES=3, RX_IN=0 for 8 cycles after a 2-cycle sync delay -> votes at edge_cnt 3,4,5; sample_valid at edge 7+1; sampled_bit=0, noise_err=0.
REQ-034 Scenario 2: prescale=16, VOTES=5, RX_IN high except low at edge_cnt 8 -> sampled_bit=1, noise_err=1.
REQ-035 Scenario 3: prescale=32, 0x55 LSB-first as 8 back-to-back bits -> 8 sample_valid pulses, 32 cycles apart; sampled_bit sequence 1,0,1,0,1,0,1,0.
REQ-036 Scenario 4: prescale=7, then prescale=6 -> cfg_err=1 in both cases, edge_cnt stays 0, no sample_valid.
REQ-037 Scenario 5: drop dat_samp_en at edge_cnt 5 of 8, then re-raise -> no pulse; edge_cnt restarts at 0; the next bit is sampled correctly.
REQ-038 Scenario 6: assert rst at edge_cnt 6 -> all outputs 0 next cycle, no sample_valid; counting resumes from 0 after release.
